// File: rtl/apu_pkg.sv
// Shared constants for the APU DAC output path.
package apu_pkg;

  localparam int unsigned FRAME_LEN          = 256;
  localparam int unsigned PCM_BITS           = 16;
  localparam int unsigned VOL_BITS           = 3;
  localparam int unsigned SAT_MAX_DEFAULT    = 63;
  localparam int unsigned PCM_OFFSET_DEFAULT = 16128;

endpackage

// File: rtl/apu_pcm_scale.sv
// Converts one unsigned mixer sum plus NR50 volume field into signed PCM.
module apu_pcm_scale
  import apu_pkg::*;
#(
  parameter int unsigned SAT_MAX    = SAT_MAX_DEFAULT,
  parameter int unsigned PCM_OFFSET = PCM_OFFSET_DEFAULT
) (
  input  logic                enable,
  input  logic [7:0]          sum,
  input  logic [VOL_BITS-1:0] volume,
  output logic [PCM_BITS-1:0] pcm
);

  localparam logic [7:0]          SatMax = 8'(SAT_MAX);
  localparam logic [PCM_BITS-1:0] Offset = PCM_BITS'(PCM_OFFSET);

  logic [5:0]        sat;
  logic [VOL_BITS:0] vol_inc;
  logic [8:0]        scaled;

  // Saturate, scale by (vol+1), shift into the upper bits and remove the DC offset.
  always_comb begin
    sat     = (sum > SatMax) ? SatMax[5:0] : sum[5:0];
    vol_inc = {1'b0, volume} + 1'b1;
    // 63 * 8 = 504 fits in 9 bits, so the product cannot wrap.
    scaled  = {3'b000, sat} * {{(9 - VOL_BITS - 1){1'b0}}, vol_inc};
    pcm     = enable ? ({1'b0, scaled, 6'b000000} - Offset) : '0;
  end

endmodule

// File: rtl/apu_dac_serializer.sv
// Left-justified stereo serializer for the WM8731: 256-clock frame, BCLK = clk/4,
// 16 data bits plus 16 pad bits per channel.
module apu_dac_serializer
  import apu_pkg::*;
#(
  parameter int unsigned SAT_MAX    = SAT_MAX_DEFAULT,
  parameter int unsigned PCM_OFFSET = PCM_OFFSET_DEFAULT
) (
  input  logic                clock12500khz,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          left,
  input  logic [7:0]          right,
  input  logic [VOL_BITS-1:0] volume_left,
  input  logic [VOL_BITS-1:0] volume_right,
  output logic                sample_strobe,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT
);

  localparam logic [7:0] LastCnt = 8'(FRAME_LEN - 1);

  logic [7:0]          cnt;
  logic [7:0]          cnt_next;
  logic                latch;
  logic [PCM_BITS-1:0] pcm_l;
  logic [PCM_BITS-1:0] pcm_r;
  logic [PCM_BITS-1:0] hold_l;
  logic [PCM_BITS-1:0] hold_r;
  logic [PCM_BITS-1:0] hold_l_next;
  logic [PCM_BITS-1:0] hold_r_next;
  logic [PCM_BITS-1:0] word;
  logic                dat_next;
  logic                strobe_next;

  apu_pcm_scale #(
    .SAT_MAX    (SAT_MAX),
    .PCM_OFFSET (PCM_OFFSET)
  ) u_scale_left (
    .enable (enable),
    .sum    (left),
    .volume (volume_left),
    .pcm    (pcm_l)
  );

  apu_pcm_scale #(
    .SAT_MAX    (SAT_MAX),
    .PCM_OFFSET (PCM_OFFSET)
  ) u_scale_right (
    .enable (enable),
    .sum    (right),
    .volume (volume_right),
    .pcm    (pcm_r)
  );

  // Next counter/hold state and the pin values that belong to the next count.
  always_comb begin
    cnt_next    = cnt + 8'd1;
    latch       = (cnt == LastCnt);
    hold_l_next = latch ? pcm_l : hold_l;
    hold_r_next = latch ? pcm_r : hold_r;
    strobe_next = (cnt_next == LastCnt);
    // Use the about-to-be-held word so the MSB at cnt 0 is the freshly latched sample.
    word        = cnt_next[7] ? hold_r_next : hold_l_next;
    // Slots 16..31 of each half-frame are zero padding.
    dat_next    = cnt_next[6] ? 1'b0 : word[~cnt_next[5:2]];
  end

  // Frame counter, sample hold registers and registered pin outputs.
  always_ff @(posedge clock12500khz or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      sample_strobe <= 1'b0;
      AUD_BCLK      <= 1'b0;
      AUD_DACLRCK   <= 1'b1;
      AUD_DACDAT    <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      hold_l        <= hold_l_next;
      hold_r        <= hold_r_next;
      sample_strobe <= strobe_next;
      AUD_BCLK      <= cnt_next[1];
      AUD_DACLRCK   <= ~cnt_next[7];
      AUD_DACDAT    <= dat_next;
    end
  end

endmodule

// File: tb/tb_apu_dac_serializer.sv
// Directed bench for apu_dac_serializer: frame format, word values, latch timing, reset.
module tb_apu_dac_serializer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] left;
  logic [7:0] right;
  logic [2:0] volume_left;
  logic [2:0] volume_right;
  logic       sample_strobe;
  logic       aud_bclk;
  logic       aud_daclrck;
  logic       aud_dacdat;

  int errors = 0;
  int checks = 0;

  logic [15:0] cap_l;
  logic [15:0] cap_r;

  apu_dac_serializer dut (
    .clock12500khz (clk),
    .reset         (reset),
    .enable        (enable),
    .left          (left),
    .right         (right),
    .volume_left   (volume_left),
    .volume_right  (volume_right),
    .sample_strobe (sample_strobe),
    .AUD_BCLK      (aud_bclk),
    .AUD_DACLRCK   (aud_daclrck),
    .AUD_DACDAT    (aud_dacdat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Walk counts from..to, sampling at negedge; check framing and record data bits.
  task automatic capture_range(input int from, input int to);
    int         bad_lr;
    int         bad_bclk;
    int         bad_strobe;
    int         bad_pad;
    logic [7:0] cc;
    bad_lr = 0;
    bad_bclk = 0;
    bad_strobe = 0;
    bad_pad = 0;
    for (int c = from; c <= to; c++) begin
      @(negedge clk);
      cc = 8'(c);
      if (aud_daclrck !== ~cc[7]) bad_lr++;
      if (aud_bclk !== cc[1]) bad_bclk++;
      if (sample_strobe !== (cc == 8'd255)) bad_strobe++;
      if (cc[6] && aud_dacdat !== 1'b0) bad_pad++;
      if (!cc[6] && cc[1:0] == 2'd2) begin
        if (cc[7]) cap_r[~cc[5:2]] = aud_dacdat;
        else       cap_l[~cc[5:2]] = aud_dacdat;
      end
    end
    chk($sformatf("lrck_%0d_%0d", from, to), bad_lr, 0);
    chk($sformatf("bclk_%0d_%0d", from, to), bad_bclk, 0);
    chk($sformatf("strobe_%0d_%0d", from, to), bad_strobe, 0);
    chk($sformatf("pad_%0d_%0d", from, to), bad_pad, 0);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    left         = 8'd0;
    right        = 8'd0;
    volume_left  = 3'd0;
    volume_right = 3'd0;
    cap_l        = '0;
    cap_r        = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_bclk", aud_bclk, 0);
    chk("rst_lrck", aud_daclrck, 1);
    chk("rst_dat", aud_dacdat, 0);
    reset = 1'b0;

    // First frame after reset is silent; strobe lands on the 256th cycle.
    cap_l = 16'hFFFF;
    cap_r = 16'hFFFF;
    cap_l[15] = 1'b0;  // cnt 0 bit was covered by rst_dat
    capture_range(1, 255);
    chk("first_l", cap_l, 16'h0000);
    chk("first_r", cap_r, 16'h0000);

    // left 60 vol 7 -> 3900; right 0 -> C100.
    left = 8'd60; volume_left = 3'd7; right = 8'd0; volume_right = 3'd0;
    capture_range(0, 255);
    chk("l60v7", cap_l, 16'h3900);
    chk("r0v0", cap_r, 16'hC100);

    // left 0 vol 3 -> C100; right 200 saturates to 63, vol 7 -> 3F00.
    left = 8'd0; volume_left = 3'd3; right = 8'd200; volume_right = 3'd7;
    capture_range(0, 255);
    chk("l0v3", cap_l, 16'hC100);
    chk("r200v7", cap_r, 16'h3F00);

    // Disabled: both words zero.
    enable = 1'b0; left = 8'd60; right = 8'd60; volume_left = 3'd7; volume_right = 3'd7;
    capture_range(0, 255);
    chk("dis_l", cap_l, 16'h0000);
    chk("dis_r", cap_r, 16'h0000);

    // Enable raised mid-frame: current frame untouched, next frame live.
    capture_range(0, 99);
    enable = 1'b1;
    capture_range(100, 255);
    chk("en_mid_l", cap_l, 16'h0000);
    chk("en_mid_r", cap_r, 16'h0000);
    capture_range(0, 255);
    chk("en_next_l", cap_l, 16'h3900);
    chk("en_next_r", cap_r, 16'h3900);

    // Input change at cnt 100 waits for the next strobe.
    capture_range(0, 99);
    left = 8'd0;
    capture_range(100, 255);
    chk("chg_cur_l", cap_l, 16'h3900);
    chk("chg_cur_r", cap_r, 16'h3900);
    capture_range(0, 255);
    chk("chg_next_l", cap_l, 16'hC100);
    chk("chg_next_r", cap_r, 16'h3900);

    // Reset at cnt 140, inside the right word (bit 12 of 3900 is 1).
    capture_range(0, 140);
    chk("pre_rst_dat", aud_dacdat, 1);
    chk("pre_rst_lrck", aud_daclrck, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_dat", aud_dacdat, 0);
    chk("mid_rst_lrck", aud_daclrck, 1);
    chk("mid_rst_bclk", aud_bclk, 0);
    chk("mid_rst_strobe", sample_strobe, 0);
    repeat (2) @(negedge clk);
    chk("held_rst_dat", aud_dacdat, 0);
    reset = 1'b0;
    cap_l = 16'h7FFF;
    cap_r = 16'hFFFF;
    capture_range(1, 255);
    chk("post_rst_l", cap_l, 16'h0000);
    chk("post_rst_r", cap_r, 16'h0000);
    capture_range(0, 255);
    chk("post_rst_next_l", cap_l, 16'hC100);
    chk("post_rst_next_r", cap_r, 16'h3900);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
